// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; parity and stop-bit config are latched as each frame starts. Optional break: UART_TX_BREAK_EN.
// Latency: a push into an empty idle FIFO is popped one cycle later, and tx drops one cycle after that; frames run back-to-back.
// Backpressure: wr_ready = !fifo_full; a push while full is dropped and sets sticky overflow.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [DATA_BITS-1:0]       wr_data,
    output logic                       wr_ready,
    input  logic                       enable_parity,
    input  logic                       parity_type,
    input  logic                       two_stop,
    input  logic                       clr_overflow,
`ifdef UART_TX_BREAK_EN
    input  logic                       break_req,
`endif
    output logic                       tx,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       overflow
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int PW  = $clog2(DEPTH);
    localparam int NW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_q, par_d;
    logic                   two_stop_q, two_stop_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic [NW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic                   push, pop, bit_end, brk;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    assign fifo_full  = (count_q == NW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_ready   = !fifo_full;
    assign push       = wr_valid && !fifo_full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        bit_d      = bit_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        bit_end    = (cnt_q == CW'(CPB - 1));
        if (state_q != S_IDLE && state_q != S_BREAK)
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        case (state_q)
            S_IDLE: begin
                if (brk) state_d = S_BREAK;
                else     pop = !fifo_empty;
            end
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA: if (bit_end) begin
                if (bit_q == IW'(DATA_BITS - 1)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + IW'(1);
                end
            end
            S_PARITY: if (bit_end) begin
                state_d = S_STOP;
                bit_d   = '0;
            end
            S_STOP: if (bit_end) begin
                if (two_stop_q && bit_q == '0) begin
                    bit_d = IW'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    pop     = !fifo_empty && !brk;
                end
            end
            S_BREAK: if (!brk) state_d = S_GAP;
            S_GAP: if (bit_end) begin
                state_d = S_IDLE;
                pop     = !fifo_empty && !brk;
            end
            default: state_d = S_IDLE;
        endcase
        // Popping always starts a fresh frame with the config sampled right now.
        if (pop) begin
            state_d    = S_START;
            cnt_d      = '0;
            bit_d      = '0;
            data_d     = mem_q[rd_ptr_q];
            par_en_d   = enable_parity;
            par_d      = (^mem_q[rd_ptr_q]) ^ parity_type;
            two_stop_d = two_stop;
        end
    end

    always_comb begin
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[bit_q];
            S_PARITY: tx_d = par_q;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
        busy_d   = (state_d != S_IDLE);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + NW'(push) - NW'(pop);
        // A dropped push wins over a clear in the same cycle.
        if (wr_valid && fifo_full) ovf_d = 1'b1;
        else if (clr_overflow)     ovf_d = 1'b0;
        else                       ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line receiver decodes tx and checks every frame against expected frames queued at push time.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       enable_parity = 1'b0;
    logic       parity_type = 1'b0;
    logic       two_stop = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       break_req = 1'b0;
    logic       tx, busy, done, fifo_empty, fifo_full, overflow;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .enable_parity(enable_parity), .parity_type(parity_type), .two_stop(two_stop),
        .clr_overflow(clr_overflow),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx), .busy(busy), .done(done), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       two_stop;
    } exp_t;

    exp_t sb[$];
    int   gap_q[$];
    int   len_q[$];
    int   checks = 0;
    int   failures = 0;
    logic last_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        sb.push_back('{d, enable_parity, parity_type, two_stop});
        tick();
        wr_valid = 1'b0;
    endtask

    function automatic int next_len();
        return (len_q.size() != 0) ? len_q.pop_front() : -1;
    endfunction

    function automatic int next_gap();
        return (gap_q.size() != 0) ? gap_q.pop_front() : -1;
    endfunction

    // Line receiver: builds the ideal waveform of the expected frame and compares sample by sample.
    exp_t        cur;
    logic        m_active = 1'b0;
    logic [11:0] m_bits;
    int          m_total, m_k, m_gap = 0, m_done_at;
    logic        m_bad, m_done_bad;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_active = 1'b0;
                m_gap    = 0;
            end else begin
                if (!m_active) begin
                    if (tx === 1'b0) begin
                        gap_q.push_back(m_gap);
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_frame: got frame start expected idle line");
                            cur = '{8'h00, 1'b0, 1'b0, 1'b0};
                        end else begin
                            cur = sb.pop_front();
                        end
                        m_bits    = '1;
                        m_bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) m_bits[1+i] = cur.data[i];
                        if (cur.par_en) m_bits[9] = (^cur.data) ^ cur.par_odd;
                        m_total    = (1 + 8 + (cur.par_en ? 1 : 0) + (cur.two_stop ? 2 : 1)) * CPB;
                        m_k        = 0;
                        m_bad      = 1'b0;
                        m_done_bad = 1'b0;
                        m_done_at  = -1;
                        m_active   = 1'b1;
                    end else begin
                        m_gap++;
                    end
                end
                if (m_active) begin
                    if (tx !== m_bits[m_k / CPB]) m_bad = 1'b1;
                    if (done !== (m_k == m_total - 1)) m_done_bad = 1'b1;
                    if (done === 1'b1 && m_done_at < 0) m_done_at = m_k + 1;
                    if (cur.par_en && m_k == 9 * CPB + CPB / 2) last_par = tx;
                    if (m_k % CPB == CPB - 1) begin
                        chk($sformatf("frame_bit%0d_data%0h_mismatch", m_k / CPB, cur.data), {31'b0, m_bad}, 32'd0);
                        m_bad = 1'b0;
                    end
                    if (m_k == m_total - 1) begin
                        chk("frame_done_pulse_misplaced", {31'b0, m_done_bad}, 32'd0);
                        len_q.push_back(m_done_at);
                        m_active = 1'b0;
                        m_gap    = 0;
                    end
                    m_k++;
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || m_active || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'b0, n >= budget}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] d [4];
        logic       pe [3], po [3], ts [3], ep [3];
        int         el [3];
        int         lows;
        int         n;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // 8N1 0xA5 with push-to-start latency
        len_q.delete();
        push_byte(8'hA5);
        chk("lat_count_e0", fifo_count, 1);
        chk("lat_busy_e0", busy, 0);
        tick();
        chk("lat_busy_e1", busy, 1);
        chk("lat_count_e1", fifo_count, 0);
        chk("lat_tx_e1", tx, 1);
        tick();
        chk("lat_tx_e2", tx, 0);
        drain(400);
        chk("len_8n1", next_len(), 160);
        chk("busy_after_8n1", busy, 0);

        pe = '{1'b1, 1'b1, 1'b1};
        po = '{1'b0, 1'b1, 1'b0};
        ts = '{1'b0, 1'b0, 1'b1};
        ep = '{1'b0, 1'b1, 1'b0};
        el = '{176, 176, 192};
        for (int i = 0; i < 3; i++) begin
            enable_parity = pe[i];
            parity_type   = po[i];
            two_stop      = ts[i];
            last_par      = 1'bx;
            len_q.delete();
            push_byte(8'hA5);
            drain(400);
            chk($sformatf("parity_bit_cfg%0d", i), {31'b0, last_par}, {31'b0, ep[i]});
            chk($sformatf("frame_len_cfg%0d", i), next_len(), el[i]);
        end

        // parity_type toggled mid-frame must not affect the frame in flight
        enable_parity = 1'b1;
        parity_type   = 1'b0;
        two_stop      = 1'b0;
        last_par      = 1'bx;
        len_q.delete();
        push_byte(8'h3C);
        repeat (20) tick();
        parity_type = 1'b1;
        drain(400);
        chk("toggle_parity_bit", {31'b0, last_par}, 32'd0);
        chk("toggle_frame_len", next_len(), 176);
        parity_type   = 1'b0;
        enable_parity = 1'b0;

        // Fill to DEPTH, drop on full (also with a simultaneous pop), push during a pop
        len_q.delete();
        gap_q.delete();
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        push_byte(8'h01);
        tick();
        chk("ovf_busy", busy, 1);
        chk("ovf_count_popped", fifo_count, 0);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i < 4) ? d[i] : 8'hEE;
            if (i < 4) sb.push_back('{d[i], 1'b0, 1'b0, 1'b0});
            tick();
            if (i == 3) begin
                chk("full_count", fifo_count, 4);
                chk("full_wr_ready", wr_ready, 0);
                chk("full_flag", fifo_full, 1);
                chk("full_no_ovf_yet", overflow, 0);
            end
        end
        wr_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count_kept", fifo_count, 4);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);
        repeat (153) tick();
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        wr_valid = 1'b0;
        chk("full_pop_drop_count", fifo_count, 3);
        chk("full_pop_drop_ovf", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        repeat (158) tick();
        wr_valid = 1'b1;
        wr_data  = 8'h78;
        sb.push_back('{8'h78, 1'b0, 1'b0, 1'b0});
        tick();
        wr_valid = 1'b0;
        chk("push_pop_count", fifo_count, 3);
        chk("push_pop_ovf", overflow, 0);
        drain(1500);
        for (int i = 0; i < 6; i++) begin
            n = next_gap();
            if (i > 0) chk($sformatf("contig_gap_frame%0d", i), n, 0);
            chk($sformatf("burst_len_frame%0d", i), next_len(), 160);
        end

        // Reset mid-DATA with 3 bytes queued
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        chk("rst_mid_queued", fifo_count, 3);
        repeat (40) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_empty", fifo_empty, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (300) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("idle_after_reset", lows, 0);
        push_byte(8'h5A);
        drain(400);

        // Randomized bursts, config fixed per burst
        for (int b = 0; b < 10; b++) begin
            enable_parity = 1'($urandom_range(0, 1));
            parity_type   = 1'($urandom_range(0, 1));
            two_stop      = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                chk("rand_wr_ready", wr_ready, 1);
                push_byte(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 20)) tick();
            end
            drain(2500);
            chk("rand_count_idle", fifo_count, 0);
            chk("rand_overflow", overflow, 0);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
